// File: rtl/zstr_drn_if.sv
// zstr_drn_if: z stream handshake bundle.
//   z_vld  source -> drain  transfer valid
//   z_bus  source -> drain  payload, BW bits
//   z_rdy  drain  -> source transfer ready
// master modport is the source side, slave modport is the drain side.
interface zstr_drn_if #(
    parameter int BW = 1
);
    logic          z_vld;
    logic [BW-1:0] z_bus;
    logic          z_rdy;

    modport master (output z_vld, output z_bus, input  z_rdy);
    modport slave  (input  z_vld, input  z_bus, output z_rdy);
endinterface

// File: rtl/zstr_drn.sv
// zstr_drn: drain end of a z stream for block-level benches.
// The bench loads per-transfer ready delays with put_tmg() and collects
// received words with get_bus(). Ready for the head transfer rises once
// z_vld has been high (without a transfer) for the programmed number of
// cycles, provided there is room in the data queue.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   zs    z stream, drain side (z_vld/z_bus in, z_rdy out)
// Params: BW payload width, QL depth of both queues (>= 1).
module zstr_drn #(
    parameter int BW = 1,
    parameter int QL = 1
) (
    input logic         clk,
    input logic         rst,
    zstr_drn_if.slave   zs
);
    localparam int CNT_MAX = 2147483647;

    // Each queue has one count/pointer owned by the task side and one
    // owned by the clock side; neither side writes the other's, so a
    // task call and a transfer on the same edge cannot lose an update.

    // task side
    int            qt [QL];
    int            qt_wcnt;
    int            qt_wpt;
    int            qb_rcnt;
    int            qb_rpt;

    // clock side
    logic [BW-1:0] qb [QL];
    int            qt_rcnt;
    int            qt_rpt;
    int            qb_wcnt;
    int            qb_wpt;
    int            z_cnt;

    int            qt_occ;
    int            qb_occ;
    logic          z_rdy_i;
    logic          z_trn;

    function automatic int nxt(input int p);
        return (p == QL - 1) ? 0 : p + 1;
    endfunction

    assign qt_occ = qt_wcnt - qt_rcnt;
    assign qb_occ = qb_wcnt - qb_rcnt;

    // Depends only on registered/queue state, never on z_vld.
    assign z_rdy_i  = rst && (qt_occ > 0) && (z_cnt >= qt[qt_rpt]) && (qb_occ < QL);
    assign zs.z_rdy = z_rdy_i;
    assign z_trn    = zs.z_vld && z_rdy_i;

    // Reset discards both queues by pulling the clock-side counts and
    // pointers level with the task-side ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qt_rcnt <= qt_wcnt;
            qt_rpt  <= qt_wpt;
            qb_wcnt <= qb_rcnt;
            qb_wpt  <= qb_rpt;
            z_cnt   <= 0;
        end else if (z_trn) begin
            qt_rcnt <= qt_rcnt + 1;
            qt_rpt  <= nxt(qt_rpt);
            qb_wcnt <= qb_wcnt + 1;
            qb_wpt  <= nxt(qb_wpt);
            z_cnt   <= 0;
        end else if (zs.z_vld && (qt_occ > 0) && (z_cnt != CNT_MAX)) begin
            // keeps counting while the data queue is full, so ready comes
            // back at once when a slot frees if the delay is already met
            z_cnt <= z_cnt + 1;
        end
    end

    // Payload storage needs no reset; occupancy is carried by the counts.
    always_ff @(posedge clk) begin
        if (z_trn)
            qb[qb_wpt] <= zs.z_bus;
    end

    task automatic put_tmg(output int sts, input int tmg);
        if (qt_wcnt - qt_rcnt < QL) begin
            qt[qt_wpt] = (tmg < 0) ? 0 : tmg;
            qt_wpt     = nxt(qt_wpt);
            qt_wcnt    = qt_wcnt + 1;
            sts        = 0;
        end else begin
            sts = 1;
        end
    endtask

    task automatic get_bus(output int sts, output logic [BW-1:0] bus);
        if (qb_wcnt - qb_rcnt > 0) begin
            bus     = qb[qb_rpt];
            qb_rpt  = nxt(qb_rpt);
            qb_rcnt = qb_rcnt + 1;
            sts     = 0;
        end else begin
            bus = {BW{1'bx}};
            sts = 1;
        end
    endtask
endmodule

// File: tb/tb_zstr_drn.sv
// tb_zstr_drn: directed and randomized bench for zstr_drn against a
// queue-based reference of the drain behaviour.
module tb_zstr_drn;
    localparam int BW      = 8;
    localparam int QL      = 4;
    localparam int CNT_MAX = 2147483647;

    logic clk;
    logic rst;

    zstr_drn_if #(.BW(BW)) zif ();

    zstr_drn #(.BW(BW), .QL(QL)) dut (
        .clk (clk),
        .rst (rst),
        .zs  (zif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // reference state
    int            m_tq[$];
    logic [BW-1:0] m_dq[$];
    int            m_cnt;

    // source stimulus
    logic [BW-1:0] src[$];
    logic          hold;
    logic          last_trn;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic m_rdy();
        if (!rst || m_tq.size() == 0 || m_dq.size() >= QL) return 1'b0;
        return m_cnt >= m_tq[0];
    endfunction

    // one clock cycle, entered and left at the falling edge
    task automatic cyc();
        logic          v;
        logic [BW-1:0] b;
        logic          r;
        v = !hold && (src.size() > 0);
        b = v ? src[0] : '0;
        zif.z_vld = v;
        zif.z_bus = b;
        if (!rst) begin
            m_tq.delete();
            m_dq.delete();
            m_cnt = 0;
        end
        #1;
        r = m_rdy();
        chk("rdy", zif.z_rdy, r);
        @(posedge clk);
        last_trn = v && r;
        if (last_trn) begin
            m_dq.push_back(b);
            void'(m_tq.pop_front());
            void'(src.pop_front());
            m_cnt = 0;
        end else if (v && m_tq.size() > 0 && m_cnt < CNT_MAX) begin
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic t_put(input int tmg);
        int s;
        int e;
        dut.put_tmg(s, tmg);
        e = (m_tq.size() >= QL) ? 1 : 0;
        if (e == 0) m_tq.push_back(tmg < 0 ? 0 : tmg);
        chk("put_sts", s, e);
    endtask

    task automatic t_get();
        int            s;
        logic [BW-1:0] b;
        dut.get_bus(s, b);
        if (m_dq.size() > 0) begin
            chk("get_sts", s, 0);
            chk("get_bus", b, m_dq.pop_front());
        end else begin
            chk("get_sts_empty", s, 1);
        end
    endtask

    // cycles elapsed before the cycle carrying the next transfer
    task automatic run_until_trn(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (last_trn) return;
            n++;
        end
        chk("trn_timeout", 0, 1);
    endtask

    initial begin
        int n;
        n_chk = 0; n_pass = 0; m_cnt = 0;
        hold = 1'b0; last_trn = 1'b0;
        zif.z_vld = 1'b0; zif.z_bus = '0;
        rst = 1'b0;

        // reset, then valid with no timing entries: never ready
        cyc();
        t_get();
        rst = 1'b1;
        src.push_back(8'h55);
        repeat (20) cyc();
        chk("no_tmg_trn", src.size(), 1);
        src.delete();

        // zero delay, back-to-back transfers
        repeat (3) t_put(0);
        src.push_back(8'h01); src.push_back(8'h02); src.push_back(8'h03);
        run_until_trn(n);
        chk("zero_dly", n, 0);
        repeat (2) cyc();
        chk("zero_cnt", src.size(), 0);
        repeat (4) t_get();

        // delay 3 after valid rises at cycle 10
        t_put(3);
        repeat (10) cyc();
        src.push_back(8'hA3);
        run_until_trn(n);
        chk("dly3", n, 3);
        t_get();

        // delay 3 with valid dropped two cycles mid-wait
        t_put(3);
        src.push_back(8'hB4);
        repeat (2) cyc();
        hold = 1'b1;
        repeat (2) cyc();
        hold = 1'b0;
        run_until_trn(n);
        chk("dly_drop", n + 4, 5);
        t_get();

        // data queue full, then release one slot
        repeat (QL) t_put(0);
        for (int i = 0; i < 6; i++) src.push_back(8'h10 + 8'(i));
        repeat (QL + 3) cyc();
        chk("full_left", src.size(), 2);
        t_put(0);
        repeat (2) cyc();
        t_get();
        run_until_trn(n);
        chk("free_dly", n, 0);
        repeat (QL) t_get();
        src.delete();

        // timing queue overflow; accepted delays honoured in order
        for (int i = 0; i < QL + 1; i++) t_put(i);
        for (int i = 0; i < QL; i++) src.push_back(8'h20 + 8'(i));
        for (int i = 0; i < QL; i++) begin
            run_until_trn(n);
            chk("ovf_dly", n, i);
        end
        repeat (QL) t_get();

        // reset while waiting discards queued data and timing
        t_put(0);
        src.push_back(8'h77);
        cyc();
        t_put(5);
        src.push_back(8'h78);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        t_get();
        rst = 1'b1;
        hold = 1'b1;
        cyc();
        t_put(1);
        hold = 1'b0;
        run_until_trn(n);
        chk("post_rst_dly", n, 1);
        t_get();
        src.delete();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) t_put(int'($urandom_range(0, 5)) - 1);
            if ($urandom_range(0, 2) == 0) t_get();
            if (src.size() < 2) src.push_back(8'($urandom));
            hold = ($urandom_range(0, 3) == 0);
            cyc();
        end
        hold = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
